// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x32 register bank: round-robin ALU/load grant, registered write, per-register pending-write scoreboard.
// Optional: define RF_ZERO_GUARD_EN to hard-wire register 0 (no writes, never busy, never counted).
`timescale 1ns/1ps
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              m_valid,
   output logic              m_ready,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic [DATA_W-1:0] m_data,
   input  logic              iss_valid,
   output logic              iss_ready,
   input  logic [ADDR_W-1:0] iss_dst,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   output logic              rf_wen,
   output logic [ADDR_W-1:0] rf_aw,
   output logic [DATA_W-1:0] rf_datow
);
   localparam int NREG = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic RR_A = 1'b0;
   localparam logic RR_M = 1'b1;

   logic              rr_q, rr_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] aw_q, aw_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic [NREG-1:0][CNT_W-1:0] cnt_q;

   logic              gnt, wr_ok, iss_fire;
   logic [ADDR_W-1:0] gnt_addr;
   logic [DATA_W-1:0] gnt_data;

   assign a_ready  = a_valid && (!m_valid || rr_q == RR_A);
   assign m_ready  = m_valid && (!a_valid || rr_q == RR_M);
   assign gnt      = a_ready || m_ready;
   assign gnt_addr = a_ready ? a_addr : m_addr;
   assign gnt_data = a_ready ? a_data : m_data;

`ifdef RF_ZERO_GUARD_EN
   // Register 0 is constant: accept the request but drop the write.
   assign wr_ok     = gnt && (gnt_addr != '0);
   assign iss_ready = (iss_dst == '0) || (cnt_q[iss_dst] != CNT_MAX);
   assign iss_fire  = iss_valid && iss_ready && (iss_dst != '0);
   assign rd_busy1  = (rd_addr1 != '0) && ((cnt_q[rd_addr1] != '0) || (wen_q && aw_q == rd_addr1));
   assign rd_busy2  = (rd_addr2 != '0) && ((cnt_q[rd_addr2] != '0) || (wen_q && aw_q == rd_addr2));
`else
   assign wr_ok     = gnt;
   assign iss_ready = (cnt_q[iss_dst] != CNT_MAX);
   assign iss_fire  = iss_valid && iss_ready;
   assign rd_busy1  = (cnt_q[rd_addr1] != '0) || (wen_q && aw_q == rd_addr1);
   assign rd_busy2  = (cnt_q[rd_addr2] != '0) || (wen_q && aw_q == rd_addr2);
`endif

   always_comb begin
      rr_d  = rr_q;
      if (a_valid && m_valid) rr_d = a_ready ? RR_M : RR_A;
      wen_d = wr_ok;
      aw_d  = wr_ok ? gnt_addr : aw_q;
      dat_d = wr_ok ? gnt_data : dat_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q  <= RR_A;
         wen_q <= 1'b0;
         aw_q  <= '0;
         dat_q <= '0;
      end else begin
         rr_q  <= rr_d;
         wen_q <= wen_d;
         aw_q  <= aw_d;
         dat_q <= dat_d;
      end
   end

   // A commit to an idle counter (unissued write) leaves it at zero.
   for (genvar r = 0; r < NREG; r++) begin : g_cnt
      localparam logic [ADDR_W-1:0] RA = ADDR_W'(r);
      logic inc, dec;
      assign inc = iss_fire && (iss_dst == RA);
      assign dec = wen_q && (aw_q == RA) && (cnt_q[r] != '0);
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)          cnt_q[r] <= '0;
         else if (inc && !dec) cnt_q[r] <= cnt_q[r] + 1'b1;
         else if (dec && !inc) cnt_q[r] <= cnt_q[r] - 1'b1;
      end
   end

   assign rf_wen   = wen_q;
   assign rf_aw    = aw_q;
   assign rf_datow = dat_q;
endmodule
